bram_controller: RTL and testbench

Single-port sample buffer controller for the audio capture path. Captures a block of 2^ADDR_WIDTH audio words from the codec sample stream into inferred block RAM, then streams the whole block back out one word per clock for the downstream FFT. Sits between the debounced user controls / codec interface and the FFT input.

---
 rtl/bram_controller.sv | 174 +++++++++++++++++
 tb/tb_bram_controller.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_controller.sv
// Single-port sample buffer: captures a 2^ADDR_WIDTH-word block into block RAM, then streams it out.
// Optional macro BRAM_CTRL_ZERO_OUT_EN: outData is forced to zero whenever readReady is low.

module bram_controller_checker (
  input logic       clk,
  input logic       reset,
  input logic [1:0] state_code,
  input logic       mem_we,
  input logic       mem_re
);

  // Only three controller states are reachable.
  a_state_legal: assert property (@(posedge clk) disable iff (reset) state_code != 2'b11);

  // The single RAM port is never asked to read and write in the same cycle.
  a_port_exclusive: assert property (@(posedge clk) disable iff (reset) !(mem_we && mem_re));

endmodule

module bram_controller #(
  parameter int WORD_WIDTH = 24,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  beginWrite,
  input  logic                  beginRead,
  input  logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [WORD_WIDTH-1:0] inData,
  input  logic                  sample,
  output logic [WORD_WIDTH-1:0] outData,
  output logic                  readReady,
  output logic                  writeComplete
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [WORD_WIDTH-1:0] WORD_ZERO = {WORD_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10
  } state_t;

  state_t                  state_r;
  logic                    write_prev_r;
  logic                    read_prev_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic [ADDR_WIDTH-1:0]   rd_addr_r;
  logic [ADDR_WIDTH-1:0]   rd_cnt_r;
  logic                    ram_valid_r;
  logic [WORD_WIDTH-1:0]   ram_q_r;
  logic [WORD_WIDTH-1:0]   mem_r [0:DEPTH-1];

  logic                    write_edge_s;
  logic                    read_edge_s;
  logic                    mem_we_s;
  logic                    mem_re_s;
  logic [ADDR_WIDTH-1:0]   mem_addr_s;

  // Request edge detection and steering of the single RAM port.
  always_comb begin
    write_edge_s = beginWrite & ~write_prev_r;
    read_edge_s  = beginRead & ~read_prev_r;
    mem_we_s     = 1'b0;
    mem_re_s     = 1'b0;
    mem_addr_s   = rd_addr_r;
    case (state_r)
      WRITE: begin
        mem_we_s   = sample;
        mem_addr_s = wr_addr_r;
      end
      READ: begin
        mem_re_s   = 1'b1;
        mem_addr_s = rd_addr_r;
      end
      default: begin
        mem_we_s   = 1'b0;
        mem_re_s   = 1'b0;
        mem_addr_s = rd_addr_r;
      end
    endcase
  end

  // RAM array and its registered read port; no reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= inData;
    end
    if (mem_re_s) begin
      ram_q_r <= mem_r[mem_addr_s];
    end
  end

  // Control FSM, address counters and the registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      write_prev_r  <= 1'b0;
      read_prev_r   <= 1'b0;
      wr_addr_r     <= ADDR_ZERO;
      rd_addr_r     <= ADDR_ZERO;
      rd_cnt_r      <= ADDR_ZERO;
      ram_valid_r   <= 1'b0;
      readReady     <= 1'b0;
      outData       <= WORD_ZERO;
      writeComplete <= 1'b0;
    end else begin
      // Previous levels update every cycle, so requests seen while busy are consumed.
      write_prev_r <= beginWrite;
      read_prev_r  <= beginRead;
      ram_valid_r  <= mem_re_s;
      readReady    <= ram_valid_r;
`ifdef BRAM_CTRL_ZERO_OUT_EN
      outData      <= ram_valid_r ? ram_q_r : WORD_ZERO;
`else
      outData      <= ram_valid_r ? ram_q_r : outData;
`endif
      case (state_r)
        IDLE: begin
          if (write_edge_s) begin
            state_r       <= WRITE;
            wr_addr_r     <= ADDR_ZERO;
            writeComplete <= 1'b0;
          end else if (read_edge_s) begin
            state_r   <= READ;
            rd_addr_r <= readAddress;
            rd_cnt_r  <= ADDR_ZERO;
          end else begin
            state_r <= IDLE;
          end
        end
        WRITE: begin
          if (sample) begin
            wr_addr_r <= wr_addr_r + ADDR_ONE;
            if (wr_addr_r == ADDR_LAST) begin
              state_r       <= IDLE;
              writeComplete <= 1'b1;
            end else begin
              state_r <= WRITE;
            end
          end else begin
            state_r <= WRITE;
          end
        end
        READ: begin
          // Address wraps naturally at the block boundary.
          rd_addr_r <= rd_addr_r + ADDR_ONE;
          rd_cnt_r  <= rd_cnt_r + ADDR_ONE;
          if (rd_cnt_r == ADDR_LAST) begin
            state_r <= IDLE;
          end else begin
            state_r <= READ;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  bram_controller_checker u_checker (
    .clk        (clk),
    .reset      (reset),
    .state_code (state_r),
    .mem_we     (mem_we_s),
    .mem_re     (mem_re_s)
  );

endmodule

// File: tb/tb_bram_controller.sv
// Bench for bram_controller at ADDR_WIDTH=3: directed tables plus randomized traffic against a transaction model.
module tb_bram_controller;

  localparam int WW = 24;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          beginWrite = 1'b0;
  logic          beginRead = 1'b0;
  logic [AW-1:0] readAddress = 3'd0;
  logic [WW-1:0] inData = 24'h000000;
  logic          sample = 1'b0;
  logic [WW-1:0] outData;
  logic          readReady;
  logic          writeComplete;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bram_controller #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .beginWrite    (beginWrite),
    .beginRead     (beginRead),
    .readAddress   (readAddress),
    .inData        (inData),
    .sample        (sample),
    .outData       (outData),
    .readReady     (readReady),
    .writeComplete (writeComplete)
  );

  // ---------------- reference model (transaction level) ----------------
  logic [WW-1:0] m_mem [N];
  int            cyc = 0;
  int            busy_until = 0;  // first edge at which a new request can be accepted
  bit            m_capturing = 1'b0;
  int            m_wr_idx = 0;
  bit            m_prev_bw = 1'b0;
  bit            m_prev_br = 1'b0;
  bit            m_wc = 1'b0;
  logic [WW-1:0] m_last = 24'h000000;
  int            pb_start[$];
  int            pb_base[$];

  task automatic model_reset();
    m_capturing = 1'b0;
    m_wr_idx    = 0;
    m_prev_bw   = 1'b0;
    m_prev_br   = 1'b0;
    m_wc        = 1'b0;
    m_last      = 24'h000000;
    busy_until  = 0;
    pb_start.delete();
    pb_base.delete();
  endtask

  task automatic model_edge();
    bit rw;
    bit rr;
    rw = beginWrite && !m_prev_bw;
    rr = beginRead && !m_prev_br;
    cyc++;
    if (m_capturing) begin
      if (sample) begin
        m_mem[m_wr_idx] = inData;
        m_wr_idx++;
        if (m_wr_idx == N) begin
          m_capturing = 1'b0;
          m_wc        = 1'b1;
          busy_until  = cyc + 1;
        end
      end
    end else if (cyc >= busy_until) begin
      if (rw) begin
        m_capturing = 1'b1;
        m_wr_idx    = 0;
        m_wc        = 1'b0;
      end else if (rr) begin
        pb_start.push_back(cyc);
        pb_base.push_back(int'(readAddress));
        busy_until = cyc + N + 1;
      end
    end
    m_prev_bw = beginWrite;
    m_prev_br = beginRead;
  endtask

  task automatic cmp_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic cmp_word(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    bit            e_rdy;
    logic [WW-1:0] e_dat;
    e_rdy = 1'b0;
`ifdef BRAM_CTRL_ZERO_OUT_EN
    e_dat = {WW{1'b0}};
`else
    e_dat = m_last;
`endif
    foreach (pb_start[i]) begin
      int off;
      off = cyc - pb_start[i] - 2;
      if (off >= 0 && off < N) begin
        e_rdy = 1'b1;
        e_dat = m_mem[(pb_base[i] + off) % N];
      end
    end
    if (e_rdy) m_last = e_dat;
    cmp_bit("model_readReady", readReady, e_rdy);
    cmp_word("model_outData", outData, e_dat);
    cmp_bit("model_writeComplete", writeComplete, m_wc);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Called about 1 time unit after an edge; asserts reset mid-cycle.
  task automatic async_reset_check();
    #3;
    reset = 1'b1;
    #1;
    cmp_word("async_rst_outData", outData, {WW{1'b0}});
    cmp_bit("async_rst_readReady", readReady, 1'b0);
    cmp_bit("async_rst_writeComplete", writeComplete, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0]        raddr;
    logic [N-1:0][WW-1:0] words;
    logic [WW-1:0]        idle;
  } rd_vec_t;

  rd_vec_t rd_tab [3];

  initial begin
    rd_tab[0] = '{raddr: 3'd0,
                  words: {24'h000088, 24'h000077, 24'h000066, 24'h000055,
                          24'h000044, 24'h000033, 24'h000022, 24'h000011},
                  idle:  24'h000088};
    rd_tab[1] = '{raddr: 3'd6,
                  words: {24'h000066, 24'h000055, 24'h000044, 24'h000033,
                          24'h000022, 24'h000011, 24'h000088, 24'h000077},
                  idle:  24'h000066};
    rd_tab[2] = '{raddr: 3'd3,
                  words: {24'h000033, 24'h000022, 24'h000011, 24'h000088,
                          24'h000077, 24'h000066, 24'h000055, 24'h000044},
                  idle:  24'h000033};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    cmp_word("reset_outData", outData, 24'h000000);
    cmp_bit("reset_readReady", readReady, 1'b0);
    cmp_bit("reset_writeComplete", writeComplete, 1'b0);
    model_reset();
    reset = 1'b0;
    step();

    // Capture 0x11..0x88 with strobes three clocks apart
    beginWrite = 1'b1;
    step();
    beginWrite = 1'b0;
    for (int k = 0; k < N; k++) begin
      inData = 24'h000011 * WW'(k + 1);
      sample = 1'b1;
      step();
      sample = 1'b0;
      cmp_bit("wc_on_strobe", writeComplete, (k == N - 1));
      step();
      step();
    end

    // Table-driven playback including wrap-around
    for (int r = 0; r < 3; r++) begin
      readAddress = rd_tab[r].raddr;
      beginRead = 1'b1;
      step();
      beginRead = 1'b0;
      step();
      cmp_bit("rd_latency_not_ready", readReady, 1'b0);
      for (int i = 0; i < N; i++) begin
        step();
        cmp_bit("rd_tab_ready", readReady, 1'b1);
        cmp_word("rd_tab_data", outData, rd_tab[r].words[i]);
      end
      step();
      cmp_bit("rd_tab_end_ready", readReady, 1'b0);
`ifdef BRAM_CTRL_ZERO_OUT_EN
      cmp_word("rd_tab_idle_data", outData, 24'h000000);
`else
      cmp_word("rd_tab_idle_data", outData, rd_tab[r].idle);
`endif
      cmp_bit("rd_tab_wc_held", writeComplete, 1'b1);
      step();
    end

    // Reset during playback clears all outputs immediately
    readAddress = 3'd1;
    beginRead = 1'b1;
    step();
    beginRead = 1'b0;
    repeat (4) step();
    async_reset_check();
    step();

    // Simultaneous edges: write wins; read pulse mid-capture ignored
    beginWrite = 1'b1;
    beginRead = 1'b1;
    readAddress = 3'd0;
    step();
    beginWrite = 1'b0;
    beginRead = 1'b0;
    for (int k = 0; k < N; k++) begin
      inData = 24'hA00000 + WW'(k);
      sample = 1'b1;
      if (k == 3) beginRead = 1'b1;
      step();
      sample = 1'b0;
      beginRead = 1'b0;
      cmp_bit("no_ready_in_capture", readReady, 1'b0);
      step();
      cmp_bit("no_ready_in_capture", readReady, 1'b0);
    end
    readAddress = 3'd5;
    beginRead = 1'b1;
    step();
    beginRead = 1'b0;
    repeat (N + 2) step();

    // Reset at the 4th strobe, then a full fresh capture
    beginWrite = 1'b1;
    step();
    beginWrite = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inData = 24'hBB0000 + WW'(k);
      sample = 1'b1;
      step();
      sample = 1'b0;
      step();
      step();
    end
    inData = 24'hBB0003;
    sample = 1'b1;
    async_reset_check();
    sample = 1'b0;
    step();
    beginWrite = 1'b1;
    step();
    beginWrite = 1'b0;
    for (int k = 0; k < N; k++) begin
      inData = 24'hC00000 + WW'(k);
      sample = 1'b1;
      step();
      sample = 1'b0;
      cmp_bit("recapture_wc", writeComplete, (k == N - 1));
      step();
    end
    readAddress = 3'd0;
    beginRead = 1'b1;
    step();
    beginRead = 1'b0;
    repeat (N + 2) step();

    // Held request level does not retrigger after playback ends
    readAddress = 3'd2;
    beginRead = 1'b1;
    step();
    repeat (N + 4) step();
    cmp_bit("held_no_retrigger", readReady, 1'b0);
    beginRead = 1'b0;
    step();

    // Back-to-back: new edge accepted in the first idle cycle
    readAddress = 3'd4;
    beginRead = 1'b1;
    step();
    beginRead = 1'b0;
    repeat (N) step();
    readAddress = 3'd7;
    beginRead = 1'b1;
    step();
    beginRead = 1'b0;
    step();
    cmp_bit("b2b_gap", readReady, 1'b0);
    step();
    cmp_bit("b2b_second_start", readReady, 1'b1);
    repeat (N + 1) step();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) beginWrite = ~beginWrite;
      if ($urandom_range(0, 5) == 0) beginRead = ~beginRead;
      sample      = ($urandom_range(0, 1) == 1);
      readAddress = AW'($urandom_range(0, N - 1));
      inData      = WW'($urandom);
      if ($urandom_range(0, 149) == 0) async_reset_check();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
